// File: rtl/imm_ext_pkg.sv
// Shared definitions for the RISC-V immediate generator: select codes and the field decoder.
// Optional ZIMM decoding is built only when IMM_EXT_ZIMM_EN is defined.
package imm_ext_pkg;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_ZIMM = 3'b101;

    // Decode is done at the widest supported XLEN; narrower users keep the low bits,
    // which is exact because every type sign-extends from instr[31].
    localparam int unsigned IMM_MAX_W = 64;

    // data bit k is instr[k+7]; result is {illegal, imm}
    function automatic logic [IMM_MAX_W:0] imm_decode(input logic [2:0]  sel,
                                                     input logic [24:0] data);
        logic [IMM_MAX_W-1:0] s;
        logic [IMM_MAX_W-1:0] imm;
        logic                 illegal;
        s       = {IMM_MAX_W{data[24]}};
        imm     = '0;
        illegal = 1'b0;
        unique case (sel)
            IMM_I: imm = {s[IMM_MAX_W-1:12], data[24:13]};
            IMM_S: imm = {s[IMM_MAX_W-1:12], data[24:18], data[4:0]};
            IMM_B: imm = {s[IMM_MAX_W-1:12], data[0], data[23:18], data[4:1], 1'b0};
            IMM_U: imm = {s[IMM_MAX_W-1:32], data[24:5], 12'b0};
            IMM_J: imm = {s[IMM_MAX_W-1:20], data[12:5], data[13], data[23:14], 1'b0};
`ifdef IMM_EXT_ZIMM_EN
            IMM_ZIMM: imm = {{(IMM_MAX_W-5){1'b0}}, data[12:8]};
`endif
            default: illegal = 1'b1;
        endcase
        return {illegal, imm};
    endfunction

endpackage

// File: rtl/imm_ext_skid.sv
// Generic 2-entry valid/ready skid buffer: registered output stage plus one overflow entry.
// in_ready is driven from registered state only, never from out_ready.
module imm_ext_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_fire;

    assign in_ready  = !skid_valid_q && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_fire;
                if (in_fire) begin
                    skid_data_d = in_data;
                end
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode into a 2-entry skid buffer.
// Define IMM_EXT_ZIMM_EN to decode sel 101 as the CSR zero-extended immediate.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [24:0]      in_imm_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned W = XLEN + 1 + TAG_W;

    logic [IMM_MAX_W:0] dec;
    logic [W-1:0]       in_data;
    logic [W-1:0]       out_data;
    logic               unused_dec;

    assign dec        = imm_decode(in_sel, in_imm_data);
    // Bits above XLEN are pure sign extension and are dropped here.
    assign unused_dec = ^dec;
    assign in_data    = {in_tag, dec[IMM_MAX_W], dec[XLEN-1:0]};

    imm_ext_skid #(
        .W(W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    assign out_imm     = out_data[XLEN-1:0];
    assign out_illegal = out_data[XLEN];
    assign out_tag     = out_data[W-1:XLEN+1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and a 2-deep FIFO model.
module tb_imm_extend_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    initial begin
        if (XLEN != 32 && XLEN != 64) $fatal(1, "unsupported XLEN %0d", XLEN);
    end

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [2:0]       in_sel;
    logic [24:0]      in_imm_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready32, in_ready64;
    logic             out_valid32, out_valid64;
    logic [XLEN-1:0]  out_imm32;
    logic [63:0]      out_imm64;
    logic             out_illegal32, out_illegal64;
    logic [TAG_W-1:0] out_tag32, out_tag64;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_sel(in_sel),
        .in_imm_data(in_imm_data), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_illegal(out_illegal32),
        .out_tag(out_tag32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_sel(in_sel),
        .in_imm_data(in_imm_data), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_illegal(out_illegal64),
        .out_tag(out_tag64)
    );

    typedef struct packed {
        logic [63:0]      imm;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    bit    last_fire;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference works on the reassembled 32-bit instruction using the ISA's bit positions.
    function automatic item_t ref_decode(input logic [2:0] sel, input logic [24:0] d,
                                         input logic [TAG_W-1:0] tag);
        logic [31:0] ins;
        longint      v;
        item_t       it;
        ins    = {d, 7'b0};
        v      = 0;
        it.ill = 1'b0;
        case (sel)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31:12], 12'b0}));
            3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
`ifdef IMM_EXT_ZIMM_EN
            3'd5: v = longint'({27'b0, ins[19:15]});
`endif
            default: it.ill = 1'b1;
        endcase
        it.imm = it.ill ? 64'd0 : 64'(v);
        it.tag = tag;
        return it;
    endfunction

    task automatic check_outputs();
        bit exp_rdy;
        bit exp_v;
        exp_rdy = !rst && (q.size() < 2);
        exp_v   = q.size() > 0;
        check_eq("in_ready32", 64'(in_ready32), 64'(exp_rdy));
        check_eq("in_ready64", 64'(in_ready64), 64'(exp_rdy));
        check_eq("out_valid32", 64'(out_valid32), 64'(exp_v));
        check_eq("out_valid64", 64'(out_valid64), 64'(exp_v));
        if (exp_v) begin
            check_eq("imm32", 64'(out_imm32), 64'(q[0].imm[XLEN-1:0]));
            check_eq("imm64", out_imm64, q[0].imm);
            check_eq("ill32", 64'(out_illegal32), 64'(q[0].ill));
            check_eq("ill64", 64'(out_illegal64), 64'(q[0].ill));
            check_eq("tag32", 64'(out_tag32), 64'(q[0].tag));
            check_eq("tag64", 64'(out_tag64), 64'(q[0].tag));
        end
    endtask

    // Inputs are stable here; advance one edge, update the model, then compare.
    task automatic step();
        int    n;
        bit    ofire;
        bit    ifire;
        item_t it;
        n     = q.size();
        ofire = (n > 0) && out_ready;
        ifire = in_valid && !rst && (n < 2);
        it    = ref_decode(in_sel, in_imm_data, in_tag);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(it);
        end
        last_fire = ifire;
        #1;
        check_outputs();
    endtask

    task automatic directed(input string name, input logic [2:0] sel, input logic [24:0] d,
                            input logic [TAG_W-1:0] tag, input logic [31:0] exp32,
                            input logic [63:0] exp64, input logic exp_ill);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_sel      = sel;
        in_imm_data = d;
        in_tag      = tag;
        step();
        in_valid = 1'b0;
        check_eq({name, "_valid"}, 64'(out_valid32), 64'd1);
        check_eq({name, "_imm32"}, 64'(out_imm32), 64'(exp32));
        check_eq({name, "_imm64"}, out_imm64, exp64);
        check_eq({name, "_ill"}, 64'(out_illegal32), 64'(exp_ill));
        check_eq({name, "_tag"}, 64'(out_tag32), 64'(tag));
        step();
    endtask

    task automatic check_zero(input string name);
        check_eq({name, "_valid"}, 64'(out_valid32 | out_valid64), 64'd0);
        check_eq({name, "_imm32"}, 64'(out_imm32), 64'd0);
        check_eq({name, "_imm64"}, out_imm64, 64'd0);
        check_eq({name, "_ill"}, 64'(out_illegal32 | out_illegal64), 64'd0);
        check_eq({name, "_tag"}, 64'(out_tag32 | out_tag64), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sel      = 3'd0;
        in_imm_data = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        step();
        step();
        check_zero("rst");
        rst = 1'b0;
        #1;
        check_eq("rdy_after_rst", 64'(in_ready32), 64'd1);

        directed("i_neg1", 3'd0, 25'h1FFE001, 5'd3, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        directed("j_p8",   3'd4, 25'h0010000, 5'd4, 32'h0000_0008, 64'h8, 1'b0);
        directed("b_m4",   3'd2, 25'h1FC001D, 5'd5, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        directed("u_pos",  3'd3, 25'h02468A0, 5'd6, 32'h1234_5000, 64'h1234_5000, 1'b0);
        directed("u_neg",  3'd3, 25'h1000000, 5'd7, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
`ifdef IMM_EXT_ZIMM_EN
        directed("zimm",   3'd5, 25'h0001F00, 5'd8, 32'h1F, 64'h1F, 1'b0);
`else
        directed("zimm",   3'd5, 25'h0001F00, 5'd8, 32'h0, 64'h0, 1'b1);
`endif
        directed("sel7",   3'd7, 25'h1FFFFFF, 5'd9, 32'h0, 64'h0, 1'b1);

        // Backpressure: two fill the buffer, the third is held until space opens.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_sel      = 3'd0;
        in_imm_data = 25'h0123456;
        in_tag      = 5'd1;
        step();
        in_tag = 5'd2;
        step();
        check_eq("bp_full_rdy", 64'(in_ready32), 64'd0);
        in_tag = 5'd3;
        step();
        step();
        check_eq("bp_hold_tag", 64'(out_tag32), 64'd1);
        out_ready = 1'b1;
        step();
        check_eq("bp_tag2", 64'(out_tag32), 64'd2);
        step();
        check_eq("bp_tag3", 64'(out_tag32), 64'd3);
        in_valid = 1'b0;
        step();
        check_eq("bp_empty", 64'(out_valid32), 64'd0);

        // Randomized traffic; a request is held until accepted.
        last_fire = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || last_fire) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                in_sel      = 3'($urandom_range(0, 7));
                in_imm_data = 25'($urandom);
                in_tag      = TAG_W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset with both entries occupied drops them.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_sel      = 3'd1;
        in_imm_data = 25'h1ABCDEF;
        in_tag      = 5'd21;
        step();
        in_tag = 5'd22;
        step();
        check_eq("prerst_full", 64'(in_ready32), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check_zero("flush");
        check_eq("flush_rdy", 64'(in_ready32 | in_ready64), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("release_rdy", 64'(in_ready32 & in_ready64), 64'd1);
        directed("post_rst", 3'd0, 25'h0064000, 5'd10, 32'h32, 64'h32, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
